// File: rtl/mesi_coherence_monitor.sv
// Scanning MESI coherence invariant monitor: one line per cycle, sticky flag, first-violation capture, saturating count.
// Optional illegal-encoding check is enabled by defining MESI_MON_ILLEGAL_ENC_CHECK_EN.
module mesi_coherence_monitor #(
    parameter int                 CPU_NUM  = 4,
    parameter int                 LINE_NUM = 10,
    parameter int                 STATE_W  = 4,
    parameter logic [STATE_W-1:0] ST_M     = 4'b1001,
    parameter logic [STATE_W-1:0] ST_E     = 4'b0101,
    parameter logic [STATE_W-1:0] ST_S     = 4'b0011,
    parameter logic [STATE_W-1:0] ST_I     = 4'b0000,
    parameter int                 CNT_W    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_i,
    input  logic                                  clr_i,
    input  logic [CPU_NUM*LINE_NUM*STATE_W-1:0]   cache_state_i,
    output logic [$clog2(LINE_NUM)-1:0]           scan_line_o,
    output logic                                  viol_pulse_o,
    output logic                                  violation_o,
    output logic [$clog2(LINE_NUM)-1:0]           first_line_o,
    output logic [CPU_NUM-1:0]                    first_cpu_mask_o,
    output logic [1:0]                            first_kind_o,
    output logic [CNT_W-1:0]                      viol_cnt_o,
    output logic                                  sweep_done_o
);
    localparam int                LW        = $clog2(LINE_NUM);
    localparam logic [LW-1:0]     LAST_LINE = LW'(LINE_NUM - 1);
    localparam logic [CPU_NUM-1:0] ONE_CPU  = {{(CPU_NUM-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [LW-1:0]                    scan_line_r;
    logic                             s1_valid_r;
    logic [LW-1:0]                    s1_line_r;
    logic [CPU_NUM-1:0][STATE_W-1:0]  s1_state_r;
    logic [CPU_NUM-1:0][STATE_W-1:0]  line_state_s;

    logic [CPU_NUM-1:0] owner_s;
    logic [CPU_NUM-1:0] illegal_s;
    logic [CPU_NUM-1:0] mask_s;
    logic [1:0]         kind_s;
    logic               me_s;
    logic               excl_s;
    logic               viol_s;

    logic               viol_pulse_r;
    logic               violation_r;
    logic [LW-1:0]      first_line_r;
    logic [CPU_NUM-1:0] first_cpu_mask_r;
    logic [1:0]         first_kind_r;
    logic [CNT_W-1:0]   viol_cnt_r;
    logic               sweep_done_r;

    // Gather the state codes of every CPU for the line under the scan pointer.
    always_comb begin
        line_state_s = '0;
        for (int c = 0; c < CPU_NUM; c++) begin
            line_state_s[c] = cache_state_i[(c*LINE_NUM + int'(scan_line_r))*STATE_W +: STATE_W];
        end
    end

    // Scan pointer and stage-1 snapshot; valid drops on a disabled edge so the pipe drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_line_r <= '0;
            s1_valid_r  <= 1'b0;
            s1_line_r   <= '0;
            s1_state_r  <= '0;
        end else if (en_i) begin
            scan_line_r <= (scan_line_r == LAST_LINE) ? '0 : scan_line_r + LW'(1);
            s1_valid_r  <= 1'b1;
            s1_line_r   <= scan_line_r;
            s1_state_r  <= line_state_s;
        end else begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Stage-2 evaluation of the snapshot: exclusivity and, optionally, illegal encodings.
    always_comb begin
        owner_s   = '0;
        illegal_s = '0;
        me_s      = 1'b0;
        for (int c = 0; c < CPU_NUM; c++) begin
            owner_s[c] = (s1_state_r[c] != ST_I);
            me_s       = me_s | (s1_state_r[c] == ST_M) | (s1_state_r[c] == ST_E);
`ifdef MESI_MON_ILLEGAL_ENC_CHECK_EN
            illegal_s[c] = !((s1_state_r[c] == ST_M) || (s1_state_r[c] == ST_E) ||
                             (s1_state_r[c] == ST_S) || (s1_state_r[c] == ST_I));
`endif
        end
        // x & (x-1) is non-zero exactly when more than one owner bit is set.
        excl_s = me_s & (|(owner_s & (owner_s - ONE_CPU)));
        mask_s = (excl_s ? owner_s : '0) | illegal_s;
        kind_s = {|illegal_s, excl_s};
        viol_s = s1_valid_r & (excl_s | (|illegal_s));
    end

    // Result registers: pulse, sticky flag, first-violation capture and saturating counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            viol_pulse_r     <= 1'b0;
            sweep_done_r     <= 1'b0;
            violation_r      <= 1'b0;
            first_line_r     <= '0;
            first_cpu_mask_r <= '0;
            first_kind_r     <= 2'b00;
            viol_cnt_r       <= '0;
        end else begin
            viol_pulse_r <= viol_s;
            sweep_done_r <= s1_valid_r && (s1_line_r == LAST_LINE);
            if (viol_s) begin
                violation_r <= 1'b1;
                if (clr_i) begin
                    viol_cnt_r <= ONE_CNT;
                end else if (viol_cnt_r != {CNT_W{1'b1}}) begin
                    viol_cnt_r <= viol_cnt_r + ONE_CNT;
                end else begin
                    viol_cnt_r <= viol_cnt_r;
                end
                if (clr_i || !violation_r) begin
                    first_line_r     <= s1_line_r;
                    first_cpu_mask_r <= mask_s;
                    first_kind_r     <= kind_s;
                end else begin
                    first_line_r     <= first_line_r;
                end
            end else if (clr_i) begin
                violation_r      <= 1'b0;
                first_line_r     <= '0;
                first_cpu_mask_r <= '0;
                first_kind_r     <= 2'b00;
                viol_cnt_r       <= '0;
            end else begin
                violation_r      <= violation_r;
            end
        end
    end

    assign scan_line_o      = scan_line_r;
    assign viol_pulse_o     = viol_pulse_r;
    assign violation_o      = violation_r;
    assign first_line_o     = first_line_r;
    assign first_cpu_mask_o = first_cpu_mask_r;
    assign first_kind_o     = first_kind_r;
    assign viol_cnt_o       = viol_cnt_r;
    assign sweep_done_o     = sweep_done_r;

endmodule

// File: doc/mesi_coherence_monitor.md
# mesi_coherence_monitor

Synthesizable, parametrised MESI coherence invariant monitor for the mesi_isc subsystem. It replaces per-line, per-CPU simulation assertions with one scanning checker that serves any CPU count and line count. It sweeps the cache-state arrays of all CPUs one line per cycle and flags exclusivity violations. It also captures the first offending line and CPU set, and keeps a saturating violation count, so the checker runs in emulation and on silicon as well as in simulation.

## Interface
Parameters:
- CPU_NUM, 4, number of CPUs monitored (2..16)
- LINE_NUM, 10, cache lines per CPU (2..1024)
- STATE_W, 4, width of one cache-state code
- ST_M / ST_E / ST_S / ST_I, 4'b1001 / 4'b0101 / 4'b0011 / 4'b0000, MESI encodings
- CNT_W, 16, violation counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en_i  in  1  scan enable
- clr_i  in  1  synchronous clear of sticky flag, capture registers and counter
- cache_state_i  in  CPU_NUM*LINE_NUM*STATE_W  flattened states; CPU c, line l at bits [(c*LINE_NUM+l)*STATE_W +: STATE_W]
- scan_line_o  out  $clog2(LINE_NUM)  line currently sampled
- viol_pulse_o  out  1  one-cycle pulse per violating line result
- violation_o  out  1  sticky: any violation since reset/clear
- first_line_o  out  $clog2(LINE_NUM)  line of first violation
- first_cpu_mask_o  out  CPU_NUM  offending CPUs of first violation
- first_kind_o  out  2  bit0 exclusivity, bit1 illegal encoding
- viol_cnt_o  out  CNT_W  saturating violation count
- sweep_done_o  out  1  one-cycle pulse when result for line LINE_NUM-1 leaves the pipeline

## Operation
- Scan pointer: while en_i=1, advances by 1 each cycle and wraps from LINE_NUM-1 to 0. It holds while en_i=0.
- Stage 1 (S1): on each en_i=1 edge, registers the CPU_NUM state codes of line scan_line_o, the line index, and a valid bit. The valid bit is cleared on an en_i=0 edge, so the pipeline drains.
- Stage 2 (S2): evaluates the S1 snapshot and registers the results.
  - owners = CPUs whose code is not ST_I.
  - Exclusivity violation: any CPU in ST_M or ST_E while popcount(owners) > 1. The mask for this violation is the owners set.
  - S coexisting only with S/I is legal. S coexisting with M/E is caught by the exclusivity rule.
- On a valid violating S2 result:
  - viol_pulse_o=1.
  - violation_o is set.
  - viol_cnt_o increments by 1, saturating at all-ones.
  - If violation_o was 0, first_line_o, first_cpu_mask_o and first_kind_o are loaded. Later violations do not overwrite them.
- clr_i=1 zeroes violation_o, the first_* registers and viol_cnt_o. If a violating result lands in the same cycle, the new violation wins: count becomes 1 and first_* are loaded. The pointer and pipeline are unaffected.
- Reset mid-scan: everything returns to its reset value immediately. The sweep restarts at line 0.

## Timing
- Reset values: scan_line_o=0, viol_pulse_o=0, violation_o=0, first_line_o=0, first_cpu_mask_o=0, first_kind_o=0, viol_cnt_o=0, sweep_done_o=0.
- Latency: line shown on scan_line_o in cycle t gives viol_pulse_o in cycle t+2 if it violates. violation_o and viol_cnt_o update in the same cycle t+2.
- A full sweep takes LINE_NUM cycles with en_i held high. The first sweep_done_o occurs LINE_NUM+1 cycles after en_i rises.
- A violation persisting across sweeps counts once per sweep.

## Configuration
- MESI_MON_ILLEGAL_ENC_CHECK_EN defined:
  - S2 also flags any code not in {ST_M, ST_E, ST_S, ST_I}.
  - first_kind_o bit1 is set for this violation, and the illegal CPUs are ORed into the mask.
  - A line with both violation kinds counts once and sets both kind bits.
- Undefined: illegal codes are treated as non-I owners only, and first_kind_o[1] is tied 0.

## Test plan
- Reset, then en_i=1 with all states ST_I for 3 sweeps → viol_pulse_o never high, viol_cnt_o=0, and sweep_done_o pulses at cycles 11, 21, 31 after en_i rise.
- CPU2 line 7 = ST_M, others ST_I; then CPU0 line 7 set to ST_S → pulse 2 cycles after scan_line_o=7, first_line_o=7, first_cpu_mask_o=4'b0101, first_kind_o=2'b01, viol_cnt_o=1.
- Hold the above violation for 5 sweeps, then pulse clr_i between sweeps → viol_cnt_o=5 before the clear and 0 after; violation_o re-sets on the next sweep.
- Lines 3 (CPU1 E + CPU3 S) and 8 (CPU0 M + CPU1 M) violating → first_line_o stays 3, mask 4'b1010, count increments per line.
- With the macro defined, CPU1 line 0 = 4'b1111 → first_kind_o=2'b10, mask 4'b0010. With the macro undefined, the same stimulus gives no violation.
- CNT_W=2, persistent violation for 6 sweeps → viol_cnt_o saturates at 3. Assert rst low mid-sweep → all outputs 0 and scan_line_o=0 within the same cycle.
